// File: rtl/centroid_steer.sv
// centroid_steer: fuses left/right colour-centroid frames into a steering error and drives two PWM motors.
// Optional CENTROID_STEER_SMOOTH_EN filters the fused position (adds one pipeline cycle).
//
// state  | meaning
// IDLE   | disabled, motors off
// SEARCH | no target, spin clockwise
// TRACK  | target seen, steer toward it
// STOP   | target close, motors off
module centroid_steer #(
  parameter int c_img_cols    = 160,
  parameter int c_pwm_bits    = 8,
  parameter int c_base_duty   = 128,
  parameter int c_search_duty = 64,
  parameter int c_kp          = 1,
  parameter int c_stop_prox   = 6,
  parameter int c_lost_frames = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              frame_tick,
  input  logic [7:0]        centroid_l,
  input  logic [7:0]        centroid_r,
  input  logic [2:0]        proximity_l,
  input  logic [2:0]        proximity_r,
  output logic              pwm_l,
  output logic              pwm_r,
  output logic              dir_l,
  output logic              dir_r,
  output logic [1:0]        state,
  output logic signed [8:0] steer_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, TRACK = 2'd2, STOP = 2'd3} state_t;

  localparam logic signed [10:0] c_half     = 11'(c_img_cols / 2);
  localparam logic signed [12:0] c_base_s   = 13'(c_base_duty);
  localparam logic signed [12:0] c_kp_s     = 13'(c_kp);
  localparam logic signed [12:0] c_max_s    = 13'((1 << c_pwm_bits) - 1);
  localparam logic [c_pwm_bits-1:0] c_search_d = c_pwm_bits'(c_search_duty);
  localparam logic [2:0]         c_stop     = 3'(c_stop_prox);
  localparam logic [7:0]         c_lost     = 8'(c_lost_frames);

  state_t st;
  logic                  s_vld;
  logic [7:0]            s_cl, s_cr;
  logic [2:0]            s_pl, s_pr;
  logic                  f_tgt;
  logic [7:0]            f_pos;
  logic [2:0]            f_prox;
  logic [8:0]            pos_sum;
  logic                  e_vld, e_tgt;
  logic [2:0]            e_prox;
  logic [9:0]            e_pos;
  logic signed [8:0]     err;
  logic signed [12:0]    prod, duty_l_raw, duty_r_raw;
  logic [7:0]            lost_cnt;
  logic [c_pwm_bits-1:0] tgt_l, tgt_r, act_l, act_r, pwm_cnt;
  logic                  tgt_dir_r;

  function automatic logic [c_pwm_bits-1:0] clamp_duty(input logic signed [12:0] v);
    if (v < 13'sd0) return '0;
    if (v > c_max_s) return '1;
    return v[c_pwm_bits-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_vld <= 1'b0;
      s_cl  <= '0;
      s_cr  <= '0;
      s_pl  <= '0;
      s_pr  <= '0;
    end else begin
      s_vld <= frame_tick & enable;
      if (frame_tick) begin
        s_cl <= centroid_l;
        s_cr <= centroid_r;
        s_pl <= proximity_l;
        s_pr <= proximity_r;
      end
    end
  end

  assign pos_sum = {1'b0, s_cl} + {1'b0, s_cr};

  always_comb begin
    f_tgt  = (s_pl != 3'd0) || (s_pr != 3'd0);
    f_pos  = s_cl;
    f_prox = s_pl;
    if (s_pl != 3'd0 && s_pr != 3'd0) begin
      f_pos  = 8'(pos_sum >> 1);
      f_prox = (s_pl > s_pr) ? s_pl : s_pr;
    end else if (s_pr != 3'd0) begin
      f_pos  = s_cr;
      f_prox = s_pr;
    end
  end

`ifdef CENTROID_STEER_SMOOTH_EN
  logic [9:0]  pos_f;
  logic [11:0] pos_mix;
  logic        p_vld, p_tgt;
  logic [2:0]  p_prox;

  assign pos_mix = 12'(pos_f) * 12'd3 + 12'(f_pos);

  // Filter restarts from the raw position whenever tracking begins afresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_f  <= '0;
      p_vld  <= 1'b0;
      p_tgt  <= 1'b0;
      p_prox <= '0;
    end else begin
      p_vld  <= s_vld & enable;
      p_tgt  <= f_tgt;
      p_prox <= f_prox;
      if (s_vld && enable && f_tgt)
        pos_f <= (st == IDLE || st == SEARCH) ? 10'(f_pos) : pos_mix[11:2];
    end
  end

  assign e_vld  = p_vld;
  assign e_tgt  = p_tgt;
  assign e_prox = p_prox;
  assign e_pos  = pos_f;
`else
  assign e_vld  = s_vld;
  assign e_tgt  = f_tgt;
  assign e_prox = f_prox;
  assign e_pos  = {2'b00, f_pos};
`endif

  assign err        = 9'($signed({1'b0, e_pos}) - c_half);
  assign prod       = 13'(err) * c_kp_s;
  assign duty_l_raw = c_base_s + prod;
  assign duty_r_raw = c_base_s - prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      lost_cnt  <= '0;
      steer_err <= '0;
      tgt_l     <= '0;
      tgt_r     <= '0;
      tgt_dir_r <= 1'b0;
    end else if (!enable) begin
      st        <= IDLE;
      lost_cnt  <= '0;
      tgt_l     <= '0;
      tgt_r     <= '0;
      tgt_dir_r <= 1'b0;
    end else begin
      if (e_vld && e_tgt) steer_err <= err;
      case (st)
        IDLE: begin
          st        <= SEARCH;
          tgt_l     <= c_search_d;
          tgt_r     <= c_search_d;
          tgt_dir_r <= 1'b1;
        end
        default: begin
          if (e_vld && e_tgt) begin
            lost_cnt  <= '0;
            tgt_dir_r <= 1'b0;
            if (e_prox >= c_stop) begin
              st    <= STOP;
              tgt_l <= '0;
              tgt_r <= '0;
            end else begin
              st    <= TRACK;
              tgt_l <= clamp_duty(duty_l_raw);
              tgt_r <= clamp_duty(duty_r_raw);
            end
          end else if (e_vld && st != SEARCH) begin
            if (lost_cnt + 8'd1 == c_lost) begin
              st        <= SEARCH;
              lost_cnt  <= '0;
              tgt_l     <= c_search_d;
              tgt_r     <= c_search_d;
              tgt_dir_r <= 1'b1;
            end else begin
              lost_cnt <= lost_cnt + 8'd1;
            end
          end
        end
      endcase
    end
  end

  // Duty and direction only change on the wrap so every PWM period is whole.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      act_l   <= '0;
      act_r   <= '0;
      dir_l   <= 1'b0;
      dir_r   <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + c_pwm_bits'(1);
      if (pwm_cnt == '1) begin
        act_l <= tgt_l;
        act_r <= tgt_r;
        dir_l <= 1'b0;
        dir_r <= tgt_dir_r;
      end
    end
  end

  assign pwm_l = (pwm_cnt < act_l);
  assign pwm_r = (pwm_cnt < act_r);
  assign state = st;

endmodule

// File: doc/centroid_steer.md
# centroid_steer

Stereo steering controller placed directly downstream of the two colour-centroid pipelines in the dual-OV7670 design. Once per processed frame it samples centroid/proximity from the left and right `color_proc` instances and fuses them into one target column. A four-state tracking FSM turns that column into a signed steering error and drives two PWM motor channels with direction bits, so the robot turns toward the detected coloured object and stops when it is close.

## Interface
Parameters:
- c_img_cols, 160, image width in pixels; centre column = c_img_cols/2
- c_pwm_bits, 8, PWM counter width; period = 2^c_pwm_bits cycles
- c_base_duty, 128, forward duty in TRACK
- c_search_duty, 64, spin duty in SEARCH
- c_kp, 1, proportional gain (unsigned, 1..7)
- c_stop_prox, 6, proximity at or above which the FSM enters STOP
- c_lost_frames, 4, consecutive target-less frames before TRACK/STOP falls back to SEARCH

Ports:
- clk  in  1  system clock (clk50mhz domain)
- rst  in  1  asynchronous, active-high reset
- enable  in  1  level; 0 forces IDLE
- frame_tick  in  1  one-cycle pulse per processed frame
- centroid_l, centroid_r  in  8  object column, 0..c_img_cols-1
- proximity_l, proximity_r  in  3  0 = no object, 7 = nearest
- pwm_l, pwm_r  out  1  motor PWM
- dir_l, dir_r  out  1  0 = forward, 1 = reverse
- state  out  2  IDLE=0, SEARCH=1, TRACK=2, STOP=3
- steer_err  out  9  signed, target column minus c_img_cols/2

## Operation
- **Sample.** On frame_tick, all four camera inputs are registered together.
- **Fusion.**
  - Both proximities nonzero: pos = (centroid_l + centroid_r) >> 1 using a 9-bit sum, and prox = max of the two.
  - Only one proximity nonzero: pos and prox come from that camera.
  - Neither nonzero: no target. steer_err holds its last value.
- **Error and duty.**
  - steer_err = pos − c_img_cols/2, computed in 9-bit signed.
  - duty_l = c_base_duty + steer_err·c_kp and duty_r = c_base_duty − steer_err·c_kp.
  - Both are computed in 13-bit signed and clamped to [0, 2^c_pwm_bits−1].
- **FSM.**
  - Any state: enable=0 goes to IDLE. In IDLE both duties are 0, dirs are 0, and lost_cnt is cleared.
  - IDLE → SEARCH on the cycle after enable=1.
  - SEARCH: duty_l = duty_r = c_search_duty, dir_l = 0, dir_r = 1 (clockwise spin). A target frame with prox < c_stop_prox goes to TRACK; a target frame with prox ≥ c_stop_prox goes to STOP.
  - TRACK: dirs 0, duties as computed. A target frame with prox ≥ c_stop_prox goes to STOP. A no-target frame increments lost_cnt and holds the duties; when lost_cnt reaches c_lost_frames, go to SEARCH. Any target frame clears lost_cnt.
  - STOP: both duties 0. A target frame with prox < c_stop_prox goes to TRACK. No-target frames follow the same lost_cnt rule as TRACK and go to SEARCH.
- **PWM.**
  - A free-running counter pwm_cnt wraps at 2^c_pwm_bits−1.
  - pwm_x = (pwm_cnt < active_duty_x), so duty 0 gives a constant low output.
  - active_duty and dir are loaded from the FSM targets only on the wrap cycle (pwm_cnt = max), so each PWM period is glitch-free.

## Timing
- Reset values: state = IDLE, pwm_l/r = 0, dir_l/r = 0, steer_err = 0, pwm_cnt = 0, lost_cnt = 0, all duty registers = 0.
- Pipeline from a frame_tick at cycle T:
  - T+1: inputs registered.
  - T+2: steer_err, state and target duties valid.
  - Next pwm_cnt wrap at or after T+2: new duty/dir take effect at the PWM pins.
- enable=0 coinciding with frame_tick: enable wins and the frame is discarded.
- enable falling mid-period: target duties go to 0 immediately, but the pins change only at the next wrap.
- A frame_tick arriving while the previous frame is still in the pipeline is processed normally. Each stage is one cycle, so there is no stall.
- An asynchronous reset during any state returns everything to the reset values immediately.

## Configuration
- `CENTROID_STEER_SMOOTH_EN` defined:
  - pos is passed through a first-order filter, pos_f = (3·pos_f + pos) >> 2, held in a 10-bit register, before the error is computed.
  - pos_f is loaded directly with pos on the first target frame after IDLE or SEARCH.
  - This adds one pipeline cycle, so targets are valid at T+3.
- Not defined: raw pos is used and targets are valid at T+2.

## Test plan
- **Track.** enable=1. Frame with cl=100, pl=3, cr=110, pr=3. Required: state=TRACK, steer_err=25, duty_l=153, duty_r=103. pwm_l is high for 153 of 256 cycles after the next wrap.
- **Single camera and clamp.** c_kp=7, cl=0, pl=0, cr=159, pr=2. Required: steer_err=79, duty_l clamps to 255, duty_r clamps to 0.
- **Stop threshold.** From TRACK, frame with pl=6. Required: state=STOP and both PWMs constantly low from the next wrap. A following frame with pl=5 returns the FSM to TRACK.
- **Loss timeout.** From TRACK, send 3 no-target frames. Required: state stays TRACK with duties held. The 4th no-target frame gives state=SEARCH, duties 64/64, dir_l=0, dir_r=1.
- **Enable/reset priority.** Drop enable on the same cycle as frame_tick. Required: state=IDLE and PWMs low after the wrap. Assert rst mid-TRACK: all outputs are 0 immediately.
- **Smoothing (macro on).** Frames with pos 80 then 120. Required: pos_f = 80, then 90, so steer_err = 0, then 10.
